// File: rtl/alu_exec_stage.sv
// Execute stage: evaluates the ALU operation when an operation is accepted and
// holds the result in a 2-entry skid buffer. The output entry drives the
// valid/ready result interface. Upstream ready is simply !skid_valid.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_alu_control,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_illegal
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic            illegal;
    logic            zero;
    logic [XLEN-1:0] result;
  } entry_t;

  entry_t out_data, skid_data, new_data;
  logic   out_valid, skid_valid;
  logic   acc, pop;
  logic   slt_bit;

  assign acc = i_valid && o_ready;
  assign pop = out_valid && i_ready;

  // Evaluate the incoming operation so it is stored already computed.
  always_comb begin
    new_data = '0;
    slt_bit  = ($signed(i_src_a) < $signed(i_src_b));
    case (i_alu_control)
      ALU_ADD: new_data.result = i_src_a + i_src_b;
      ALU_SUB: new_data.result = i_src_a - i_src_b;
      ALU_AND: new_data.result = i_src_a & i_src_b;
      ALU_OR:  new_data.result = i_src_a | i_src_b;
      ALU_SLT: new_data.result = {{(XLEN-1){1'b0}}, slt_bit};
      default: new_data.illegal = 1'b1;
    endcase
    new_data.zero = (new_data.result == '0);
  end

  // Output/skid entry update; a full skid implies a full output entry, and
  // acceptance is impossible while the skid is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid) begin
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= new_data;
      end
    end else if (pop) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_data <= new_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= new_data;
    end
  end

  assign o_ready   = !skid_valid;
  assign o_valid   = out_valid;
  assign o_result  = out_data.result;
  assign o_zero    = out_data.zero;
  assign o_illegal = out_data.illegal;

endmodule
